sync_fifo_thresh: RTL and testbench

//  Parametrised single-clock FIFO. Successor to the basic 4x8 sync FIFO.

---
 rtl/sync_fifo_thresh.sv | 111 +++++++++++
 tb/tb_sync_fifo_thresh.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thresh.sv
// rtl/sync_fifo_thresh.sv - single-clock FIFO with occupancy count, almost-full/empty flags and read-valid strobe
// Optional sticky OVERFLOW/UNDERFLOW flags with ERR_CLR when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_thresh #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  R_EN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                  ERR_CLR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  generate
    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "sync_fifo_thresh: FIFO_DEPTH must equal 2**ADDR_WIDTH");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
      $fatal(1, "sync_fifo_thresh: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
      $fatal(1, "sync_fifo_thresh: AEMPTY_THRESH out of range");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status is a pure decode of the registered pointers, so it settles once per edge.
  always_comb begin
    COUNT        = wptr - rptr;
    EMPTY        = (wptr == rptr);
    FULL         = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    ALMOST_FULL  = (COUNT >= AF_LVL);
    ALMOST_EMPTY = (COUNT <= AE_LVL);
    wr_ok        = W_EN & ~FULL;
    rd_ok        = R_EN & ~EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr       <= '0;
      rptr       <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr       <= rptr + PTR_ONE;
        DATA_OUT   <= mem[rptr[ADDR_WIDTH-1:0]];
        DATA_VALID <= 1'b1;
      end else begin
        DATA_VALID <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  // A new error on the same edge as ERR_CLR must not be lost, so set has priority.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (W_EN & FULL) begin
        OVERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        OVERFLOW <= 1'b0;
      end
      if (R_EN & EMPTY) begin
        UNDERFLOW <= 1'b1;
      end else if (ERR_CLR) begin
        UNDERFLOW <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb/tb_sync_fifo_thresh.sv - directed self-checking bench for sync_fifo_thresh
// Covers SYNC_FIFO_ERR_EN error flags only when that macro is defined.
module tb_sync_fifo_thresh;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
`endif

  int total;
  int bad;

  sync_fifo_thresh dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .W_EN         (w_en),
    .DATA_IN      (data_in),
    .R_EN         (r_en),
    .DATA_OUT     (data_out),
    .DATA_VALID   (data_valid),
    .FULL         (full),
    .EMPTY        (empty),
    .ALMOST_FULL  (almost_full),
    .ALMOST_EMPTY (almost_empty),
    .COUNT        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .ERR_CLR      (err_clr),
    .OVERFLOW     (overflow),
    .UNDERFLOW    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    step(); step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%0b exp=1", almost_empty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%0b exp=0", almost_full); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", data_valid); end
    total++; if (data_out !== 8'd0) begin bad++; $display("FAIL reset_dout got=%0d exp=0", data_out); end
`ifdef SYNC_FIFO_ERR_EN
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      w_en = 1'b1; data_in = 8'(i);
      step();
      total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      total++; if (almost_empty !== (i <= 4)) begin bad++; $display("FAIL fill_aempty[%0d] got=%0b exp=%0b", i, almost_empty, (i <= 4)); end
      total++; if (almost_full !== (i >= 12)) begin bad++; $display("FAIL fill_afull[%0d] got=%0b exp=%0b", i, almost_full, (i >= 12)); end
      total++; if (full !== (i == 16)) begin bad++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == 16)); end
    end
    data_in = 8'd99;
    step();
    w_en = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_17th_count got=%0d exp=16", count); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_17th_full got=%0b exp=1", full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      r_en = 1'b1;
      step();
      total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%0b exp=1", i, data_valid); end
      total++; if (data_out !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%0d exp=%0d", i, data_out, i); end
      total++; if (count !== 5'(16 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 16 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    step();
    r_en = 1'b0;
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL drain_extra_valid got=%0b exp=0", data_valid); end
    total++; if (data_out !== 8'd16) begin bad++; $display("FAIL drain_extra_hold got=%0d exp=16", data_out); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      w_en = 1'b1; data_in = 8'(100 + k);
      step();
    end
    r_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      data_in = 8'(108 + j);
      step();
      total++; if (count !== 5'd8) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=8", j, count); end
      total++; if (data_out !== 8'(100 + j) || data_valid !== 1'b1) begin
        bad++; $display("FAIL b2b_data[%0d] got=%0d/%0b exp=%0d/1", j, data_out, data_valid, 100 + j);
      end
    end
    w_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      total++; if (data_out !== 8'(120 + j)) begin bad++; $display("FAIL b2b_tail[%0d] got=%0d exp=%0d", j, data_out, 120 + j); end
    end
    r_en = 1'b0;
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_boundary();
    w_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_in = 8'(200 + k);
      step();
    end
    r_en = 1'b1; data_in = 8'd77;
    step();
    w_en = 1'b1; r_en = 1'b0; w_en = 1'b0;
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_wr_rd_count got=%0d exp=15", count); end
    total++; if (data_out !== 8'd200 || data_valid !== 1'b1) begin bad++; $display("FAIL full_wr_rd_data got=%0d/%0b exp=200/1", data_out, data_valid); end
    r_en = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step();
      total++; if (data_out !== 8'(200 + k)) begin bad++; $display("FAIL full_drain[%0d] got=%0d exp=%0d", k, data_out, 200 + k); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%0b exp=1", empty); end
    w_en = 1'b1; data_in = 8'd55;
    step();
    w_en = 1'b0; r_en = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_wr_rd_count got=%0d exp=1", count); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL empty_wr_rd_valid got=%0b exp=0", data_valid); end
    total++; if (data_out !== 8'd215) begin bad++; $display("FAIL empty_wr_rd_hold got=%0d exp=215", data_out); end
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    total++; if (data_out !== 8'd55 || data_valid !== 1'b1) begin bad++; $display("FAIL empty_wr_rd_read got=%0d/%0b exp=55/1", data_out, data_valid); end
  endtask

  task automatic test_reset_mid();
    w_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_in = 8'(30 + k);
      step();
    end
    w_en = 1'b0;
    total++; if (count !== 5'd6) begin bad++; $display("FAIL mid_pre_count got=%0d exp=6", count); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL mid_rst_status got=%0d/%0b/%0b exp=0/1/0", count, empty, full);
    end
    total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL mid_rst_almost got=%0b/%0b exp=1/0", almost_empty, almost_full); end
    total++; if (data_out !== 8'd0 || data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_data got=%0d/%0b exp=0/0", data_out, data_valid); end
    step();
    rst_n = 1'b1;
    w_en = 1'b1; data_in = 8'd9;
    step();
    w_en = 1'b0; r_en = 1'b1;
    step();
    r_en = 1'b0;
    total++; if (data_out !== 8'd9 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst_after got=%0d/%0b exp=9/1", data_out, empty); end
  endtask

`ifdef SYNC_FIFO_ERR_EN
  task automatic test_errors();
    w_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data_in = 8'(k);
      step();
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL err_no_ovf got=%0b exp=0", overflow); end
    step();
    w_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL err_ovf_set got=%0b exp=1", overflow); end
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL err_ovf_sticky got=%0b exp=1", overflow); end
    w_en = 1'b1; err_clr = 1'b1;
    step();
    w_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL err_ovf_set_wins got=%0b exp=1", overflow); end
    step();
    err_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL err_ovf_clr got=%0b exp=0", overflow); end
    r_en = 1'b1;
    for (int k = 0; k < 16; k++) step();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL err_no_unf got=%0b exp=0", underflow); end
    step();
    r_en = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL err_unf_set got=%0b exp=1", underflow); end
    step();
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL err_unf_sticky got=%0b exp=1", underflow); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL err_unf_clr got=%0b exp=0", underflow); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
`ifdef SYNC_FIFO_ERR_EN
    test_errors();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
